pulse_stretch_tx: RTL and testbench
===================================

# pulse_stretch_tx

- Transmit side of the fast-to-slow narrow-pulse crossing.
- Accepts single-cycle event pulses in the fast `clk` domain and queues them in a pending counter.
- Emits each event as a registered pulse exactly HIGH_CYC cycles wide, followed by a GAP_CYC low gap, so that a slow-domain two-flop capture sees every event as a distinct pulse.
- Sits directly upstream of the slow-domain pulse synchronizer; `pulse_out` is the only signal that crosses.

## Interface

- HIGH_CYC, 4: width of each emitted pulse in `clk` cycles; legal range ≥1.
- GAP_CYC, 4: minimum low time between emitted pulses in `clk` cycles; legal range ≥1.
- CNT_W, 4: pending-counter width; the queue depth is 2^CNT_W−1 events.
- clk  in  1  fast-domain clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- pulse_in  in  1  event strobe; each high cycle is one event.
- pulse_out  out  1  stretched pulse, registered; goes to the slow domain.
- busy  out  1  registered; 1 when state≠IDLE or pending≠0.
- pending  out  CNT_W  registered count of events accepted but not yet launched.
- overflow  out  1  registered one-cycle strobe; 1 when an event was dropped.

## Operation

- FSM states: IDLE, HIGH, GAP. A down-counter `tcnt` is wide enough for max(HIGH_CYC, GAP_CYC).
- **Launch condition `go`:** `pulse_in` is 1, or `pending` is non-zero.
- **IDLE:**
  - If `go`, move to HIGH and load `tcnt` = HIGH_CYC−1.
  - A launch caused by `pulse_in` while `pending`=0 bypasses the counter.
- **HIGH:**
  - `tcnt` decrements each cycle.
  - When `tcnt`=0, move to GAP and load `tcnt` = GAP_CYC−1.
- **GAP:**
  - `tcnt` decrements each cycle.
  - When `tcnt`=0: if `go`, move directly to HIGH with no IDLE cycle; otherwise move to IDLE.
- **Launch priority:** when `pending`≠0, the launch consumes a queued event. `pulse_in` in that same cycle is then queued.
- **Pending update each cycle**, with inc = `pulse_in` that is not consumed by a bypass launch, and dec = a launch that consumes a queued event:
  - inc and dec both 1: `pending` unchanged.
  - inc only: `pending`+1, unless `pending` = 2^CNT_W−1. In that case the event is dropped and `overflow`=1 on the next cycle.
  - dec only: `pending`−1.
- `pending` never wraps in either direction.
- `pulse_out` is a registered copy of (next state == HIGH), so it is glitch-free and is 1 exactly while the state is HIGH.
- `busy` = (state≠IDLE) | (`pending`≠0), registered with the same update.
- **Reset (rst_n=0), at any time including mid-pulse:**
  - State goes to IDLE and `tcnt`, `pending`, `pulse_out`, `busy` and `overflow` all go to 0 immediately (asynchronously).
  - Queued events are discarded; no partial pulse resumes after release.

## Timing

- **Latency:** `pulse_in` high in cycle t with the FSM in IDLE → `pulse_out` high in cycles t+1 … t+HIGH_CYC.
- **Throughput:** back-to-back emitted pulses have a period of exactly HIGH_CYC+GAP_CYC cycles. Low time between them is exactly GAP_CYC cycles.
- **Post-pulse low time:** after the last emitted pulse, `pulse_out` stays low for at least GAP_CYC cycles before any new pulse.
- **busy deassertion:** `busy` falls in the first IDLE cycle, which is HIGH_CYC+GAP_CYC+1 cycles after the last launch cycle.
- **Register update timing:** `pending` and `overflow` update on the edge after the causing `pulse_in` cycle.
- **Integration rule:** for a slow clock of period Ts and fast clock period Tf, the integrator sets HIGH_CYC·Tf > 2·Ts and GAP_CYC·Tf > 2·Ts. The block does not check this.

## Test plan

All scenarios use HIGH_CYC=4 and GAP_CYC=4 unless stated.

- **Single event:** `pulse_in` in cycle 10 → `pulse_out`=1 in cycles 11–14 and 0 from 15. `busy`=1 in cycles 11–18 and 0 at 19. `pending` stays 0.
- **Burst of 3:** `pulse_in` in cycles 10, 11, 12 → `pulse_out` high in 11–14, 19–22 and 27–30. `pending` is 1 at 12, 2 at 13, 1 at 19, 0 at 27. `busy` falls at 35.
- **Overflow (CNT_W=2):** `pulse_in` in cycles 10–14 → `pending` reaches 3 at 14. The cycle-14 event is dropped and `overflow`=1 in cycle 15 only. Exactly 4 output pulses follow, with a period of 8.
- **Relaunch at end of GAP:** single event at cycle 10, then `pulse_in` in cycle 18 (the last GAP cycle) → second pulse in 19–22 with no IDLE cycle. `busy` stays 1 throughout.
- **Simultaneous inc/dec:** `pending`=2 and `pulse_in` in the launch cycle → `pending` stays 2 that cycle and drops to 1 one period later.
- **Reset mid-HIGH:** `rst_n` low in cycle 12 of a burst → `pulse_out`, `busy`, `pending` and `overflow` are 0 immediately. After release with no input, `pulse_out` stays 0.

Source files
------------

// File: rtl/pulse_stretch_tx.sv
// Fast-domain transmit side of a narrow-pulse crossing: queues single-cycle events
// and replays each one as a fixed-width pulse followed by a guaranteed low gap.
module pulse_stretch_tx #(
  parameter int HIGH_CYC = 4,
  parameter int GAP_CYC  = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int MAX_CYC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0]    HIGH_LOAD = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0]    GAP_LOAD  = TW'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;
  logic [CNT_W-1:0] pending_nxt;
  logic             overflow_nxt;
  logic             go, launch, bypass, inc, dec;

  assign go = pulse_in | (pending != '0);

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          launch    = 1'b1;
          state_nxt = HIGH;
          tcnt_nxt  = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (tcnt == '0) begin
          state_nxt = GAP;
          tcnt_nxt  = GAP_LOAD;
        end else begin
          tcnt_nxt = tcnt - TW'(1);
        end
      end
      GAP: begin
        // A waiting event relaunches straight from the last gap cycle, keeping the period exact
        if (tcnt == '0) begin
          if (go) begin
            launch    = 1'b1;
            state_nxt = HIGH;
            tcnt_nxt  = HIGH_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          tcnt_nxt = tcnt - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tcnt_nxt  = '0;
      end
    endcase
  end

  // Queued events take priority; only an empty queue lets pulse_in launch directly
  assign bypass = launch & (pending == '0);
  assign dec    = launch & (pending != '0);
  assign inc    = pulse_in & ~bypass;

  always_comb begin
    pending_nxt  = pending;
    overflow_nxt = 1'b0;
    if (inc && !dec) begin
      if (pending == PEND_MAX) begin
        overflow_nxt = 1'b1;
      end else begin
        pending_nxt = pending + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      pending_nxt = pending - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      pending   <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      pending   <= pending_nxt;
      pulse_out <= (state_nxt == HIGH);
      busy      <= (state_nxt != IDLE) | (pending_nxt != '0);
      overflow  <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// Directed bench for pulse_stretch_tx: expected pulses and overflow strobes are queued
// by the stimulus and matched by an independent monitor.
module tb_pulse_stretch_tx;

  localparam int HIGH_CYC = 4;
  localparam int GAP_CYC  = 4;
  localparam int CNT_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulse_in = 1'b0;
  logic             pulse_out, busy, overflow;
  logic [CNT_W-1:0] pending;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int start;
    int width;
  } pulse_t;

  pulse_t exp_pulses[$];
  int     exp_ovf[$];
  int     exp_pend[64];
  int     exp_busy[64];
  int     exp_out[64];
  logic   prev_out = 1'b0;
  int     start_cyc = 0;

  pulse_stretch_tx #(
    .HIGH_CYC(HIGH_CYC),
    .GAP_CYC (GAP_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .pulse_out(pulse_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s rel_cycle=%0d actual=%0d expected=%0d", name, cyc - base, actual, expected);
    end
  endtask

  task automatic clearTables();
    for (int i = 0; i < 64; i++) begin
      exp_pend[i] = -1;
      exp_busy[i] = -1;
      exp_out[i]  = -1;
    end
  endtask

  task automatic pushPulses(input int first, input int count);
    pulse_t p;
    for (int i = 0; i < count; i++) begin
      p.start = first + i * (HIGH_CYC + GAP_CYC);
      p.width = HIGH_CYC;
      exp_pulses.push_back(p);
    end
  endtask

  // Drives mask[s] during relative cycle s and checks the per-cycle tables
  task automatic applyStimulus(input logic [63:0] mask, input int len);
    @(negedge clk);
    base = cyc;
    for (int s = 0; s < len; s++) begin
      if (s > 0) @(negedge clk);
      pulse_in = mask[s];
      if (exp_pend[s] >= 0) checkOutput("pending", int'(pending), exp_pend[s]);
      if (exp_busy[s] >= 0) checkOutput("busy", int'(busy), exp_busy[s]);
      if (exp_out[s] >= 0) checkOutput("pulse_out", int'(pulse_out), exp_out[s]);
    end
    @(negedge clk);
    pulse_in = 1'b0;
  endtask

  always @(negedge clk) begin
    pulse_t e;
    if (!rst_n) begin
      prev_out = 1'b0;
    end else begin
      if (pulse_out && !prev_out) start_cyc = cyc;
      if (!pulse_out && prev_out) begin
        if (exp_pulses.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pulse start=%0d width=%0d expected=none", start_cyc - base, cyc - start_cyc);
        end else begin
          e = exp_pulses.pop_front();
          checkOutput("pulse_start", start_cyc - base, e.start);
          checkOutput("pulse_width", cyc - start_cyc, e.width);
        end
      end
      prev_out = pulse_out;
      if (overflow) begin
        if (exp_ovf.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_overflow rel_cycle=%0d actual=1 expected=0", cyc - base);
        end else begin
          checkOutput("overflow_cycle", cyc - base, exp_ovf.pop_front());
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    checkOutput("reset_pulse_out", int'(pulse_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_pending", int'(pending), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single event");
    clearTables();
    exp_busy[11] = 1; exp_busy[18] = 1; exp_busy[19] = 0;
    exp_pend[12] = 0; exp_pend[15] = 0;
    pushPulses(11, 1);
    applyStimulus(64'h1 << 10, 25);

    $display("[TB] burst of three");
    clearTables();
    exp_pend[12] = 1; exp_pend[13] = 2; exp_pend[19] = 1; exp_pend[27] = 0;
    exp_busy[34] = 1; exp_busy[35] = 0;
    pushPulses(11, 3);
    applyStimulus(64'h7 << 10, 41);

    $display("[TB] overflow");
    clearTables();
    exp_pend[14] = 3; exp_pend[15] = 3; exp_pend[19] = 2; exp_pend[27] = 1; exp_pend[35] = 0;
    exp_busy[42] = 1; exp_busy[43] = 0;
    pushPulses(11, 4);
    exp_ovf.push_back(15);
    applyStimulus(64'h1F << 10, 49);

    $display("[TB] relaunch at end of gap");
    clearTables();
    for (int s = 11; s <= 26; s++) exp_busy[s] = 1;
    exp_busy[27] = 0;
    exp_pend[19] = 0;
    pushPulses(11, 2);
    applyStimulus((64'h1 << 10) | (64'h1 << 18), 30);

    $display("[TB] simultaneous inc and dec");
    clearTables();
    exp_pend[18] = 2; exp_pend[19] = 2; exp_pend[26] = 2; exp_pend[27] = 1; exp_pend[35] = 0;
    exp_busy[42] = 1; exp_busy[43] = 0;
    pushPulses(11, 4);
    applyStimulus((64'h7 << 10) | (64'h1 << 18), 49);

    $display("[TB] reset mid-high");
    clearTables();
    exp_out[11] = 1;
    exp_pend[11] = 0;
    applyStimulus(64'h3 << 10, 12);
    checkOutput("pre_reset_pending", int'(pending), 1);
    checkOutput("pre_reset_pulse_out", int'(pulse_out), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_pulse_out", int'(pulse_out), 0);
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_pending", int'(pending), 0);
    checkOutput("async_overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearTables();
    for (int s = 0; s < 20; s++) begin
      exp_out[s]  = 0;
      exp_busy[s] = 0;
      exp_pend[s] = 0;
    end
    applyStimulus(64'h0, 20);

    checkOutput("pulses_left", exp_pulses.size(), 0);
    checkOutput("overflows_left", exp_ovf.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
